// File: rtl/rv32_stim_gen.sv
// Seedable random RV32I stimulus generator: a Galois LFSR drives an encoder for
// ALU-imm/ALU-reg/load/store words, buffered through a valid/ready FIFO.
module rv32_stim_gen #(
    parameter int          DEPTH         = 4,
    parameter logic [31:0] SEED          = 32'h000003FA,
    parameter int          WARMUP_NOPS   = 4,
    parameter int          NUM_INSTR     = 100,
    parameter logic [11:0] LOAD_IMM_MASK = 12'hFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  mode_mask,
    input  logic        seed_load,
    input  logic [31:0] seed_in,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr_bits,
    output logic [31:0] gen_count,
    output logic        busy,
    output logic        done
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] NOP       = 32'h00000013;
    localparam logic [31:0] TAPS      = 32'h80200003;
    localparam logic [AW:0] FULL      = (AW + 1)'(DEPTH);
    localparam logic [31:0] WARM_LAST = 32'(WARMUP_NOPS - 1);
    localparam logic [31:0] NUM_LIM   = 32'(NUM_INSTR);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WARMUP = 2'd1, S_GEN = 2'd2, S_DONE = 2'd3} state_t;

    state_t         state_q;
    logic [31:0]    lfsr_q;
    logic [31:0]    gen_count_q;
    logic [31:0]    warm_cnt_q;
    logic [3:0]     mode_q;
    logic           busy_q;
    logic           done_q;
    logic [31:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    occ_q;
    logic [AW:0]    occ_d;
    logic           push_s;
    logic           pop_s;
    logic [31:0]    push_word_s;

    // Decode one instruction word from the current LFSR state.
    function automatic logic [31:0] encode(input logic [31:0] r, input logic [3:0] m);
        logic [1:0]  cls;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  f7;
        logic [31:0] enc;
        cls = r[1:0];
        if (!m[cls]) begin
            cls = 2'd0;
        end
        f3  = r[19:17];
        imm = r[31:20];
        enc = NOP;
        case (cls)
            2'd0: begin
                if (f3 == 3'd1) begin
                    imm = imm & 12'h01F;
                end else if (f3 == 3'd5) begin
                    imm = imm & 12'h41F;
                end
                enc = {imm, r[11:7], f3, r[6:2], 7'b0010011};
            end
            2'd1: begin
                f7  = ((f3 == 3'd0) || (f3 == 3'd5)) ? {1'b0, r[20], 5'b00000} : 7'd0;
                enc = {f7, r[16:12], r[11:7], f3, r[6:2], 7'b0110011};
            end
            2'd2: begin
                enc = {imm & LOAD_IMM_MASK, r[11:7], f3 & 3'b100, r[6:2], 7'b0000011};
            end
            2'd3: begin
                imm = imm & LOAD_IMM_MASK;
                enc = {imm[11:5], r[16:12], r[11:7], 3'b010, imm[4:0], 7'b0100011};
            end
            default: enc = NOP;
        endcase
        return enc;
    endfunction

    // Push/pop qualification and the word offered to the FIFO this cycle.
    always_comb begin
        instr_valid = (occ_q != '0);
        pop_s       = instr_valid & instr_ready;
        push_s      = (state_q != S_IDLE) && (occ_q < FULL);
        if (state_q == S_GEN) begin
            push_word_s = encode(lfsr_q, mode_q);
        end else begin
            push_word_s = NOP;
        end
        if (instr_valid) begin
            instr_bits = mem_q[rd_ptr_q];
        end else begin
            instr_bits = NOP;
        end
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + (AW + 1)'(1);
            2'b01:   occ_d = occ_q - (AW + 1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Run-control FSM with LFSR, counters and registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED;
            gen_count_q <= 32'd0;
            warm_cnt_q  <= 32'd0;
            mode_q      <= 4'b0001;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if ((state_q == S_IDLE) && seed_load) begin
                        lfsr_q <= (seed_in == 32'd0) ? SEED : seed_in;
                    end
                    if (start) begin
                        mode_q      <= mode_mask | 4'b0001;
                        gen_count_q <= 32'd0;
                        warm_cnt_q  <= 32'd0;
                        state_q     <= (WARMUP_NOPS == 0) ? S_GEN : S_WARMUP;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                S_WARMUP: begin
                    if (push_s) begin
                        warm_cnt_q <= warm_cnt_q + 32'd1;
                        if (warm_cnt_q == WARM_LAST) begin
                            state_q <= S_GEN;
                        end
                    end
                end
                S_GEN: begin
                    if (push_s) begin
                        lfsr_q      <= lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
                        gen_count_q <= gen_count_q + 32'd1;
                        if ((NUM_LIM != 32'd0) && (gen_count_q + 32'd1 == NUM_LIM)) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; reset discards any buffered words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            occ_q <= occ_d;
        end
    end

    // FIFO storage; contents are meaningless while occupancy says empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= push_word_s;
        end
    end

    assign gen_count = gen_count_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_rv32_stim_gen.sv
// Scoreboard bench for rv32_stim_gen: a reference model queues the expected
// word stream, and a negedge monitor checks every word the consumer accepts.
module tb_rv32_stim_gen;
    localparam int          DEPTH = 4;
    localparam logic [31:0] SEED  = 32'h000003FA;
    localparam int          WARM  = 2;
    localparam int          NUM   = 20;
    localparam logic [11:0] MASK  = 12'h3FF;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  mode_mask = 4'b0001;
    logic        seed_load = 1'b0;
    logic [31:0] seed_in = 32'd0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr_bits;
    logic [31:0] gen_count;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic [31:0] model_lfsr = SEED;
    bit          fifo_empty_known = 1'b1;

    rv32_stim_gen #(
        .DEPTH(DEPTH), .SEED(SEED), .WARMUP_NOPS(WARM),
        .NUM_INSTR(NUM), .LOAD_IMM_MASK(MASK)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode_mask(mode_mask),
        .seed_load(seed_load), .seed_in(seed_in), .instr_ready(instr_ready),
        .instr_valid(instr_valid), .instr_bits(instr_bits), .gen_count(gen_count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_next(input logic [31:0] r);
        return (r % 32'd2 == 32'd1) ? ((r >> 1) ^ 32'h80200003) : (r >> 1);
    endfunction

    // Reference encoder built from field arithmetic on the LFSR word.
    function automatic logic [31:0] ref_word(input logic [31:0] r, input logic [3:0] m);
        int unsigned cls, rd, rs1, rs2, f3, imm, f7;
        cls = r % 32'd4;
        if (m[cls] == 1'b0) cls = 0;
        rd  = (r >> 2) % 32'd32;
        rs1 = (r >> 7) % 32'd32;
        rs2 = (r >> 12) % 32'd32;
        f3  = (r >> 17) % 32'd8;
        imm = r >> 20;
        case (cls)
            0: begin
                if (f3 == 1) imm = imm % 32;
                if (f3 == 5) imm = (imm & 32'h400) + imm % 32;
                return 32'(imm * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 32'h13);
            end
            1: begin
                f7 = (f3 == 0 || f3 == 5) ? ((r >> 20) % 32'd2) * 32 : 0;
                return 32'(f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 32'h33);
            end
            2: begin
                imm = imm & 32'(MASK);
                f3  = (f3 >= 4) ? 4 : 0;
                return 32'(imm * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 32'h03);
            end
            default: begin
                imm = imm & 32'(MASK);
                return 32'((imm / 32) * 33554432 + rs2 * 1048576 + rs1 * 32768 + 2 * 4096 + (imm % 32) * 128 + 32'h23);
            end
        endcase
    endfunction

    function automatic bit legal(input logic [31:0] w);
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [11:0] imm_s;
        f7 = w[31:25];
        f3 = w[14:12];
        imm_s = {w[31:25], w[11:7]};
        case (w[6:0])
            7'h13:   return (f3 == 3'd1) ? (f7 == 7'h00) :
                            (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            7'h33:   return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            7'h03:   return (f3 == 3'd0 || f3 == 3'd4) && ((w[31:20] & ~MASK) == 12'd0);
            7'h23:   return (f3 == 3'd2) && ((imm_s & ~MASK) == 12'd0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: every accepted word is popped against the scoreboard queue.
    always @(negedge clk) begin
        if (reset_n && instr_valid && instr_ready) begin
            mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : NOP;
            check("stream", instr_bits, mon_exp);
            check("legal", 32'(legal(instr_bits)), 32'd1);
        end else if (reset_n && !instr_valid) begin
            check("empty_nop", instr_bits, NOP);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_bits"}, instr_bits, NOP);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_gen"}, gen_count, 32'd0);
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        reset_checks("reset");
        exp_q.delete();
        model_lfsr = SEED;
        fifo_empty_known = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic start_run(input logic [3:0] mm, input bit do_seed, input logic [31:0] sd, input bit golden);
        if (!fifo_empty_known) begin
            instr_ready = 1'b0;
            repeat (DEPTH + 2) tick();
            repeat (DEPTH) exp_q.push_back(NOP);
        end
        mode_mask = mm;
        seed_load = do_seed;
        seed_in   = sd;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        seed_load = 1'b0;
        if (do_seed) model_lfsr = (sd == 32'd0) ? SEED : sd;
        repeat (WARM) exp_q.push_back(NOP);
        for (int i = 0; i < NUM; i++) begin
            if (golden && i == 0) exp_q.push_back(32'h00038F13);
            else exp_q.push_back(ref_word(model_lfsr, mm | 4'b0001));
            model_lfsr = lfsr_next(model_lfsr);
        end
        fifo_empty_known = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // rmode 0: ready high; 1: random ready; 2: ready dropped for 10 cycles mid-GEN.
    task automatic finish_run(input int rmode);
        int c;
        logic [31:0] held;
        c = 0;
        held = 32'd0;
        while (!(done && exp_q.size() == 0) && c < 3000) begin
            case (rmode)
                0:       instr_ready = 1'b1;
                1:       instr_ready = ($urandom_range(0, 3) != 0);
                default: instr_ready = !(c >= 6 && c < 16);
            endcase
            tick();
            c++;
            if (rmode == 2 && c == 11) held = gen_count;
            if (rmode == 2 && c == 16) begin
                check("stall_gen_frozen", gen_count, held);
                check("stall_valid", 32'(instr_valid), 32'd1);
                check("stall_busy", 32'(busy), 32'd1);
            end
        end
        if (c >= 3000) begin
            errors++;
            $display("FAIL run_timeout: got %0d cycles expected done within 3000", c);
        end
        check("run_done", 32'(done), 32'd1);
        check("run_busy", 32'(busy), 32'd0);
        check("run_gen_count", gen_count, 32'(NUM));
        instr_ready = 1'b1;
        repeat (5) tick();
    endtask

    initial begin
        #2;
        reset_checks("por");
        tick();
        reset_n = 1'b1;
        tick();

        start_run(4'b0001, 1'b0, 32'd0, 1'b1);
        finish_run(0);
        start_run(4'b1111, 1'b0, 32'd0, 1'b0);
        finish_run(2);

        do_reset();
        start_run(4'b1111, 1'b1, 32'd0, 1'b0);
        finish_run(1);

        for (int k = 0; k < 2; k++) begin
            do_reset();
            start_run(4'b1111, 1'b1, 32'hDEADBEEF, 1'b0);
            finish_run(k);
        end

        for (int k = 0; k < 50; k++) begin
            start_run((k % 5 == 4) ? 4'($urandom_range(0, 15)) : 4'b1111, 1'b0, 32'd0, 1'b0);
            finish_run(1);
        end

        do_reset();
        instr_ready = 1'b0;
        start_run(4'b1111, 1'b0, 32'd0, 1'b0);
        repeat (8) tick();
        check("full_gen_count", gen_count, 32'(DEPTH - WARM));
        check("full_valid", 32'(instr_valid), 32'd1);
        do_reset();
        tick();
        reset_checks("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
